// File: rtl/shared_resource_arbiter.sv
// Two-requester round-robin arbiter and response router around a single-cycle doubling resource.
// Latency: request accepted at cycle t, result written to its response FIFO at t+1, visible at t+2.
// Backpressure: per-requester credits equal FIFO depth; a stalled consumer only blocks its own requester.

// Response FIFO: in-order buffer, head presented combinationally, drops writes when full without a pop.
// Latency: write at edge t, visible on o_vld after that edge.
// Backpressure: push while full is legal only together with a pop; otherwise the write is dropped and flagged.
module srarb_rsp_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_push,
   input  logic [W-1:0] i_push_dat,
   input  logic         i_pop,
   output logic         o_vld,
   output logic [W-1:0] o_dat,
   output logic         o_ovf
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = $clog2(DEPTH + 1);

   logic [W-1:0]     r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [OCC_W-1:0] r_count;

   logic w_full;
   logic w_pop_ok;
   logic w_push_ok;

   assign w_full    = (r_count == OCC_W'(DEPTH));
   assign w_pop_ok  = i_pop & (r_count != '0);
   // A full FIFO can still take a write when the head leaves in the same cycle.
   assign w_push_ok = i_push & (~w_full | w_pop_ok);
   assign o_ovf     = i_push & w_full & ~w_pop_ok;
   assign o_vld     = (r_count != '0);
   assign o_dat     = r_mem[r_rd_ptr];

   // Storage array; no reset needed since occupancy gates visibility.
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= i_push_dat;
      end
   end

   // Pointers wrap naturally at the power-of-two depth; occupancy tracks push/pop balance.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + OCC_W'(1);
            2'b01:   r_count <= r_count - OCC_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

module shared_resource_arbiter #(
   parameter int DATA_W    = 32,
   parameter int RSP_DEPTH = 4,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid_1,
   input  logic [DATA_W-1:0] req_data_1,
   output logic              req_ready_1,
   input  logic              req_valid_2,
   input  logic [DATA_W-1:0] req_data_2,
   output logic              req_ready_2,
   output logic              rsp_valid_1,
   output logic [DATA_W-1:0] rsp_data_1,
   input  logic              rsp_ready_1,
   output logic              rsp_valid_2,
   output logic [DATA_W-1:0] rsp_data_2,
   input  logic              rsp_ready_2,
   output logic              res_in_valid_1,
   output logic              res_in_valid_2,
   output logic [DATA_W-1:0] res_input,
   input  logic              res_out_valid_1,
   input  logic              res_out_valid_2,
   input  logic [DATA_W-1:0] res_output,
   output logic              stall_1,
   output logic              stall_2,
   output logic [CNT_W-1:0]  grant_cnt_1,
   output logic [CNT_W-1:0]  grant_cnt_2,
   output logic              err
);
   localparam int CR_W = $clog2(RSP_DEPTH + 1);
   localparam logic [CR_W-1:0] CR_FULL = CR_W'(RSP_DEPTH);

   logic [CR_W-1:0]  r_credit_1;
   logic [CR_W-1:0]  r_credit_2;
   logic             r_last_grant_2;   // 1: requester 2 was granted most recently
   logic [CNT_W-1:0] r_grant_cnt_1;
   logic [CNT_W-1:0] r_grant_cnt_2;
   logic             r_err;

   logic              w_elig_1;
   logic              w_elig_2;
   logic              w_grant_1;
   logic              w_grant_2;
   logic              w_fifo_vld_1;
   logic              w_fifo_vld_2;
   logic              w_pop_1;
   logic              w_pop_2;
   logic              w_ovf_1;
   logic              w_ovf_2;
   logic [DATA_W-1:0] w_fifo_dat_1;
   logic [DATA_W-1:0] w_fifo_dat_2;

   // A requester may only be issued when its FIFO has a reserved slot for the result.
   assign w_elig_1 = ~reset & req_valid_1 & (r_credit_1 != '0);
   assign w_elig_2 = ~reset & req_valid_2 & (r_credit_2 != '0);

   // Round-robin: on a tie, the requester that did not win last time goes first.
   assign w_grant_1 = w_elig_1 & (~w_elig_2 | r_last_grant_2);
   assign w_grant_2 = w_elig_2 & (~w_elig_1 | ~r_last_grant_2);

   assign req_ready_1    = w_grant_1;
   assign req_ready_2    = w_grant_2;
   assign res_in_valid_1 = w_grant_1;
   assign res_in_valid_2 = w_grant_2;
   assign stall_1        = ~reset & req_valid_1 & ~w_grant_1;
   assign stall_2        = ~reset & req_valid_2 & ~w_grant_2;

   // Shared resource data path carries the winner's operand, zero when idle.
   always_comb begin
      res_input = '0;
      if (w_grant_1) begin
         res_input = req_data_1;
      end else if (w_grant_2) begin
         res_input = req_data_2;
      end
   end

   // Visible outputs are forced low during reset even before the first reset edge lands.
   assign rsp_valid_1 = ~reset & w_fifo_vld_1;
   assign rsp_valid_2 = ~reset & w_fifo_vld_2;
   assign rsp_data_1  = w_fifo_dat_1;
   assign rsp_data_2  = w_fifo_dat_2;
   assign w_pop_1     = rsp_valid_1 & rsp_ready_1;
   assign w_pop_2     = rsp_valid_2 & rsp_ready_2;
   assign grant_cnt_1 = reset ? '0 : r_grant_cnt_1;
   assign grant_cnt_2 = reset ? '0 : r_grant_cnt_2;
   assign err         = ~reset & r_err;

   srarb_rsp_fifo #(.W(DATA_W), .DEPTH(RSP_DEPTH)) u_fifo_1 (
      .clk        (clk),
      .reset      (reset),
      .i_push     (res_out_valid_1),
      .i_push_dat (res_output),
      .i_pop      (w_pop_1),
      .o_vld      (w_fifo_vld_1),
      .o_dat      (w_fifo_dat_1),
      .o_ovf      (w_ovf_1)
   );

   srarb_rsp_fifo #(.W(DATA_W), .DEPTH(RSP_DEPTH)) u_fifo_2 (
      .clk        (clk),
      .reset      (reset),
      .i_push     (res_out_valid_2),
      .i_push_dat (res_output),
      .i_pop      (w_pop_2),
      .o_vld      (w_fifo_vld_2),
      .o_dat      (w_fifo_dat_2),
      .o_ovf      (w_ovf_2)
   );

   // Credits: consumed on issue, returned on pop; both in one cycle cancel out.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_credit_1 <= CR_FULL;
         r_credit_2 <= CR_FULL;
      end else begin
         case ({w_grant_1, w_pop_1})
            2'b10:   r_credit_1 <= r_credit_1 - CR_W'(1);
            2'b01:   r_credit_1 <= r_credit_1 + CR_W'(1);
            default: r_credit_1 <= r_credit_1;
         endcase
         case ({w_grant_2, w_pop_2})
            2'b10:   r_credit_2 <= r_credit_2 - CR_W'(1);
            2'b01:   r_credit_2 <= r_credit_2 + CR_W'(1);
            default: r_credit_2 <= r_credit_2;
         endcase
      end
   end

   // Round-robin pointer; reset state makes requester 1 win the first tie.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_last_grant_2 <= 1'b1;
      end else if (w_grant_1) begin
         r_last_grant_2 <= 1'b0;
      end else if (w_grant_2) begin
         r_last_grant_2 <= 1'b1;
      end
   end

   // Saturating per-requester grant counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_grant_cnt_1 <= '0;
         r_grant_cnt_2 <= '0;
      end else begin
         if (w_grant_1 && !(&r_grant_cnt_1)) begin
            r_grant_cnt_1 <= r_grant_cnt_1 + CNT_W'(1);
         end
         if (w_grant_2 && !(&r_grant_cnt_2)) begin
            r_grant_cnt_2 <= r_grant_cnt_2 + CNT_W'(1);
         end
      end
   end

   // Sticky overflow flag: a result arrived with no room and was dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_err <= 1'b0;
      end else if (w_ovf_1 || w_ovf_2) begin
         r_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_shared_resource_arbiter.sv
// Bench for shared_resource_arbiter: occupancy-based reference model checked every cycle,
// plus directed scenarios with literal expectations. Includes a registered doubling resource.
// Counters run at CNT_W=4 so saturation is reachable quickly.
module tb_shared_resource_arbiter;
   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int CW    = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid_1, req_valid_2, req_ready_1, req_ready_2;
   logic [DW-1:0] req_data_1, req_data_2;
   logic          rsp_valid_1, rsp_valid_2, rsp_ready_1, rsp_ready_2;
   logic [DW-1:0] rsp_data_1, rsp_data_2;
   logic          res_in_valid_1, res_in_valid_2;
   logic [DW-1:0] res_input;
   logic          res_out_valid_1, res_out_valid_2;
   logic [DW-1:0] res_output;
   logic          stall_1, stall_2, err;
   logic [CW-1:0] grant_cnt_1, grant_cnt_2;

   int n_chk  = 0;
   int n_pass = 0;

   shared_resource_arbiter #(.DATA_W(DW), .RSP_DEPTH(DEPTH), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset),
      .req_valid_1(req_valid_1), .req_data_1(req_data_1), .req_ready_1(req_ready_1),
      .req_valid_2(req_valid_2), .req_data_2(req_data_2), .req_ready_2(req_ready_2),
      .rsp_valid_1(rsp_valid_1), .rsp_data_1(rsp_data_1), .rsp_ready_1(rsp_ready_1),
      .rsp_valid_2(rsp_valid_2), .rsp_data_2(rsp_data_2), .rsp_ready_2(rsp_ready_2),
      .res_in_valid_1(res_in_valid_1), .res_in_valid_2(res_in_valid_2), .res_input(res_input),
      .res_out_valid_1(res_out_valid_1), .res_out_valid_2(res_out_valid_2), .res_output(res_output),
      .stall_1(stall_1), .stall_2(stall_2),
      .grant_cnt_1(grant_cnt_1), .grant_cnt_2(grant_cnt_2), .err(err)
   );

   always #5 clk = ~clk;

   // Single-cycle doubling resource sharing the arbiter's reset.
   always @(posedge clk) begin
      if (reset) begin
         res_out_valid_1 <= 1'b0;
         res_out_valid_2 <= 1'b0;
         res_output      <= '0;
      end else begin
         res_out_valid_1 <= res_in_valid_1;
         res_out_valid_2 <= res_in_valid_2;
         res_output      <= res_input << 1;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
      else n_pass++;
   endtask

   // Reference model: per-requester queues of results in flight and buffered.
   logic [DW-1:0] f1[$], f2[$], p1[$], p2[$];
   int            pt1[$], pt2[$];
   logic [DW-1:0] log1[$], log2[$];
   int            m_last, m_gc1, m_gc2, cyc, acc1, acc2, g;
   logic          e1, e2;
   logic [DW-1:0] exp_in;

   initial begin
      cyc = 0; acc1 = 0; acc2 = 0; m_last = 2; m_gc1 = 0; m_gc2 = 0;
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (reset) begin
         chk("reset_outputs",
             {15'd0, req_ready_1, req_ready_2, res_in_valid_1, res_in_valid_2,
              rsp_valid_1, rsp_valid_2, stall_1, stall_2, err, grant_cnt_1, grant_cnt_2}, 32'd0);
         f1.delete(); f2.delete(); p1.delete(); p2.delete(); pt1.delete(); pt2.delete();
         m_last = 2; m_gc1 = 0; m_gc2 = 0;
      end else begin
         while (pt1.size() > 0 && pt1[0] <= cyc) begin f1.push_back(p1.pop_front()); void'(pt1.pop_front()); end
         while (pt2.size() > 0 && pt2[0] <= cyc) begin f2.push_back(p2.pop_front()); void'(pt2.pop_front()); end
         e1 = req_valid_1 && (p1.size() + f1.size() < DEPTH);
         e2 = req_valid_2 && (p2.size() + f2.size() < DEPTH);
         g = 0;
         if (e1 && e2) g = (m_last == 1) ? 2 : 1;
         else if (e1)  g = 1;
         else if (e2)  g = 2;
         exp_in = (g == 1) ? req_data_1 : (g == 2) ? req_data_2 : '0;
         chk("req_ready_1", {31'd0, req_ready_1}, {31'd0, g == 1});
         chk("req_ready_2", {31'd0, req_ready_2}, {31'd0, g == 2});
         chk("res_in_valid", {30'd0, res_in_valid_1, res_in_valid_2}, {30'd0, g == 1, g == 2});
         chk("res_input", res_input, exp_in);
         chk("stall", {30'd0, stall_1, stall_2}, {30'd0, req_valid_1 && g != 1, req_valid_2 && g != 2});
         chk("rsp_valid", {30'd0, rsp_valid_1, rsp_valid_2}, {30'd0, f1.size() > 0, f2.size() > 0});
         if (f1.size() > 0) chk("rsp_data_1", rsp_data_1, f1[0]);
         if (f2.size() > 0) chk("rsp_data_2", rsp_data_2, f2[0]);
         chk("grant_cnt", {24'd0, grant_cnt_1, grant_cnt_2}, {24'd0, 4'(m_gc1), 4'(m_gc2)});
         chk("err", {31'd0, err}, 32'd0);
         // Observations for the directed scenarios.
         if (req_ready_1) acc1++;
         if (req_ready_2) acc2++;
         if (rsp_valid_1 && rsp_ready_1) log1.push_back(rsp_data_1);
         if (rsp_valid_2 && rsp_ready_2) log2.push_back(rsp_data_2);
         // Advance the model to the state after the coming edge.
         if (g == 1) begin p1.push_back(req_data_1 << 1); pt1.push_back(cyc + 2); m_last = 1; if (m_gc1 < 15) m_gc1++; end
         if (g == 2) begin p2.push_back(req_data_2 << 1); pt2.push_back(cyc + 2); m_last = 2; if (m_gc2 < 15) m_gc2++; end
         if (f1.size() > 0 && rsp_ready_1) void'(f1.pop_front());
         if (f2.size() > 0 && rsp_ready_2) void'(f2.pop_front());
      end
   end

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic rst_pulse();
      reset = 1'b1; step(1); reset = 1'b0;
   endtask

   int b1, b2, l1, l2;

   initial begin
      reset = 1'b1;
      req_valid_1 = 1'b1; req_data_1 = 32'd1;
      req_valid_2 = 1'b0; req_data_2 = '0;
      rsp_ready_1 = 1'b1; rsp_ready_2 = 1'b1;
      step(2);
      @(negedge clk);
      chk("lit_reset_ready_1", {31'd0, req_ready_1}, 32'd0);

      // Solo stream 1..5.
      @(posedge clk); #1;
      reset = 1'b0;
      l1 = log1.size();
      @(negedge clk);
      chk("lit_first_ready_1", {31'd0, req_ready_1}, 32'd1);
      @(posedge clk); #1;
      for (int k = 2; k <= 5; k++) begin req_data_1 = k; step(1); end
      req_valid_1 = 1'b0;
      step(4);
      chk("lit_solo_cnt_1", {28'd0, grant_cnt_1}, 32'd5);
      chk("lit_solo_nrsp", log1.size() - l1, 32'd5);
      for (int k = 0; k < 5; k++)
         if (l1 + k < log1.size()) chk("lit_solo_rsp", log1[l1 + k], 32'(2 * (k + 1)));

      // Contention, 8 cycles.
      rst_pulse();
      req_valid_1 = 1'b1; req_data_1 = 32'd5;
      req_valid_2 = 1'b1; req_data_2 = 32'd7;
      @(negedge clk);
      chk("lit_cont_first_tie", {30'd0, req_ready_1, req_ready_2}, 32'd2);
      @(posedge clk); #1;
      step(7);
      req_valid_1 = 1'b0; req_valid_2 = 1'b0;
      chk("lit_cont_cnt_1", {28'd0, grant_cnt_1}, 32'd4);
      chk("lit_cont_cnt_2", {28'd0, grant_cnt_2}, 32'd4);
      step(4);
      chk("lit_cont_rsp_1", log1[log1.size() - 1], 32'd10);
      chk("lit_cont_rsp_2", log2[log2.size() - 1], 32'd14);

      // Backpressure on consumer 1.
      rst_pulse();
      rsp_ready_1 = 1'b0;
      req_valid_1 = 1'b1; req_valid_2 = 1'b1;
      b1 = acc1; l1 = log1.size();
      for (int k = 0; k < 12; k++) begin
         if (k == 8) b2 = acc2;
         req_data_1 = 32'(10 + k); req_data_2 = 32'(100 + k);
         step(1);
      end
      chk("lit_bp_accepts_1", acc1 - b1, 32'd4);
      chk("lit_bp_rate_2", acc2 - b2, 32'd4);
      @(negedge clk);
      chk("lit_bp_stall_1", {31'd0, stall_1}, 32'd1);
      @(posedge clk); #1;
      rsp_ready_1 = 1'b1;
      step(10);
      req_valid_1 = 1'b0; req_valid_2 = 1'b0;
      step(6);
      chk("lit_bp_resumed", {31'd0, (acc1 - b1) > 4}, 32'd1);
      for (int k = 0; k < 4; k++)
         if (l1 + k < log1.size()) chk("lit_bp_order", log1[l1 + k], 32'(20 + 4 * k));

      // Wrap-around doubling.
      l1 = log1.size();
      req_valid_1 = 1'b1; req_data_1 = 32'h8000_0001; step(1);
      req_data_1 = 32'hFFFF_FFFF; step(1);
      req_valid_1 = 1'b0; step(4);
      chk("lit_wrap_nrsp", log1.size() - l1, 32'd2);
      if (log1.size() >= l1 + 2) begin
         chk("lit_wrap_a", log1[l1], 32'h0000_0002);
         chk("lit_wrap_b", log1[l1 + 1], 32'hFFFF_FFFE);
      end

      // Counter saturation.
      rst_pulse();
      req_valid_1 = 1'b1; req_data_1 = 32'd3;
      step(20);
      req_valid_1 = 1'b0; step(3);
      chk("lit_sat_cnt_1", {28'd0, grant_cnt_1}, 32'd15);

      // Reset with responses buffered in FIFO 2.
      rst_pulse();
      rsp_ready_2 = 1'b0;
      req_valid_2 = 1'b1; req_data_2 = 32'd9;
      step(3);
      req_valid_2 = 1'b0; step(3);
      chk("lit_mid_buffered", {31'd0, rsp_valid_2}, 32'd1);
      reset = 1'b1; req_valid_1 = 1'b1; req_valid_2 = 1'b1;
      step(1);
      reset = 1'b0;
      @(negedge clk);
      chk("lit_mid_flushed", {31'd0, rsp_valid_2}, 32'd0);
      chk("lit_mid_tie", {30'd0, req_ready_1, req_ready_2}, 32'd2);
      @(posedge clk); #1;
      req_valid_1 = 1'b0;
      b2 = acc2;
      step(4);
      chk("lit_mid_accepts_2", acc2 - b2, 32'd4);
      req_valid_2 = 1'b0; rsp_ready_2 = 1'b1;
      step(8);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
